// File: rtl/cache_arb_pkg.sv
// Shared types and default sizing for the two-master cache port arbiter.
package cache_arb_pkg;

  localparam int unsigned DEFAULT_ADDR_SIZE = 16;
  localparam int unsigned DEFAULT_DATA_SIZE = 32;
  localparam int unsigned DEFAULT_BVAL_SIZE = 4;
  localparam int unsigned DEFAULT_TIMEOUT   = 255;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Bundle of the two master request/response ports and the shared cache port.
interface cache_port_arbiter_if #(
  parameter int unsigned ADDR_SIZE = cache_arb_pkg::DEFAULT_ADDR_SIZE,
  parameter int unsigned DATA_SIZE = cache_arb_pkg::DEFAULT_DATA_SIZE,
  parameter int unsigned BVAL_SIZE = cache_arb_pkg::DEFAULT_BVAL_SIZE
);

  logic [ADDR_SIZE-1:0] m0_addr,  m1_addr;
  logic [DATA_SIZE-1:0] m0_wdata, m1_wdata;
  logic [BVAL_SIZE-1:0] m0_bval,  m1_bval;
  logic                 m0_rd,    m1_rd;
  logic                 m0_wr,    m1_wr;
  logic [DATA_SIZE-1:0] m0_rdata, m1_rdata;
  logic                 m0_ack,   m1_ack;
  logic                 m0_err,   m1_err;

  logic [ADDR_SIZE-1:0] s_addr;
  logic [DATA_SIZE-1:0] s_wdata;
  logic [BVAL_SIZE-1:0] s_bval;
  logic                 s_rd;
  logic                 s_wr;
  logic [DATA_SIZE-1:0] s_rdata;
  logic                 s_ack;

  logic                 busy;

  // Arbiter side.
  modport slave (
    input  m0_addr, m0_wdata, m0_bval, m0_rd, m0_wr,
    input  m1_addr, m1_wdata, m1_bval, m1_rd, m1_wr,
    output m0_rdata, m0_ack, m0_err,
    output m1_rdata, m1_ack, m1_err,
    output s_addr, s_wdata, s_bval, s_rd, s_wr,
    input  s_rdata, s_ack,
    output busy
  );

  // Environment side: the two masters plus the cache.
  modport master (
    output m0_addr, m0_wdata, m0_bval, m0_rd, m0_wr,
    output m1_addr, m1_wdata, m1_bval, m1_rd, m1_wr,
    input  m0_rdata, m0_ack, m0_err,
    input  m1_rdata, m1_ack, m1_err,
    input  s_addr, s_wdata, s_bval, s_rd, s_wr,
    output s_rdata, s_ack,
    input  busy
  );

endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache port between two masters, with an
// s_ack timeout that returns an error response to the owning master.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int unsigned BVAL_SIZE = DEFAULT_BVAL_SIZE,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
  input logic                 c_clk,
  input logic                 rst,
  cache_port_arbiter_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  arb_state_e           state_q;
  logic                 owner_q;
  logic                 last_grant_q;
  logic [CntW-1:0]      cnt_q;

  logic [ADDR_SIZE-1:0] s_addr_q;
  logic [DATA_SIZE-1:0] s_wdata_q;
  logic [BVAL_SIZE-1:0] s_bval_q;
  logic                 s_rd_q, s_wr_q;
  logic [DATA_SIZE-1:0] m0_rdata_q, m1_rdata_q;
  logic                 m0_ack_q, m0_err_q, m1_ack_q, m1_err_q;

  logic                 req0, req1, winner, win_rd, win_wr;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [DATA_SIZE-1:0] win_wdata;
  logic [BVAL_SIZE-1:0] win_bval;
  logic                 rsp_done;
  logic [DATA_SIZE-1:0] rsp_data;

  always_comb begin
    req0      = bus.m0_rd | bus.m0_wr;
    req1      = bus.m1_rd | bus.m1_wr;
    // On a tie the master that did not win last time goes first.
    winner    = (req0 & req1) ? ~last_grant_q : req1;
    win_addr  = winner ? bus.m1_addr  : bus.m0_addr;
    win_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
    win_bval  = winner ? bus.m1_bval  : bus.m0_bval;
    win_rd    = winner ? bus.m1_rd    : bus.m0_rd;
    win_wr    = winner ? bus.m1_wr    : bus.m0_wr;
    // s_ack beats a timeout landing on the same edge.
    rsp_done  = bus.s_ack | (cnt_q == CntLast);
    rsp_data  = bus.s_ack ? bus.s_rdata : '0;
  end

  always_ff @(posedge c_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_bval_q     <= '0;
      s_rd_q       <= 1'b0;
      s_wr_q       <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            owner_q      <= winner;
            last_grant_q <= winner;
            cnt_q        <= '0;
            s_addr_q     <= win_addr;
            s_wdata_q    <= win_wdata;
            s_bval_q     <= win_bval;
            s_wr_q       <= win_wr;
            s_rd_q       <= win_rd & ~win_wr;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.s_ack) begin
            cnt_q <= cnt_q + CntW'(1);
          end
          if (rsp_done) begin
            s_rd_q  <= 1'b0;
            s_wr_q  <= 1'b0;
            state_q <= RESP;
            if (owner_q) begin
              m1_rdata_q <= rsp_data;
              m1_ack_q   <= 1'b1;
              m1_err_q   <= ~bus.s_ack;
            end else begin
              m0_rdata_q <= rsp_data;
              m0_ack_q   <= 1'b1;
              m0_err_q   <= ~bus.s_ack;
            end
          end
        end
        RESP: begin
          m0_ack_q <= 1'b0;
          m0_err_q <= 1'b0;
          m1_ack_q <= 1'b0;
          m1_err_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_bval   = s_bval_q;
  assign bus.s_rd     = s_rd_q;
  assign bus.s_wr     = s_wr_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m0_err   = m0_err_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m1_err   = m1_err_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a transaction-level reference model.
module tb_cache_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 8;

  logic c_clk = 1'b0;
  logic rst   = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  cache_port_arbiter_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .BVAL_SIZE(BW)) bus ();

  cache_port_arbiter #(
    .ADDR_SIZE(AW),
    .DATA_SIZE(DW),
    .BVAL_SIZE(BW),
    .TIMEOUT  (TO)
  ) dut (
    .c_clk(c_clk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 c_clk = ~c_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: expected outputs for the coming cycle.
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [BW-1:0] e_bval;
  logic          e_rd, e_wr, e_busy;
  logic [DW-1:0] e_rdata [2];
  logic [1:0]    e_ack, e_err;
  int            busy_cycles;   // BUSY cycles elapsed in current transaction, 0 if none
  bit            responding, owner, lastg, armed;

  task automatic model_reset();
    e_addr = '0; e_wdata = '0; e_bval = '0; e_rd = 0; e_wr = 0; e_busy = 0;
    e_rdata[0] = '0; e_rdata[1] = '0; e_ack = '0; e_err = '0;
    busy_cycles = 0; responding = 0; lastg = 1; owner = 0;
  endtask

  initial begin
    bit r0, r1;
    model_reset();
    armed = 0;
    forever begin
      @(negedge c_clk);
      if (armed) begin
        check("s_port",
              64'({bus.s_addr, bus.s_wdata, bus.s_bval, bus.s_rd, bus.s_wr, bus.busy}),
              64'({e_addr, e_wdata, e_bval, e_rd, e_wr, e_busy}));
        check("m0_resp", 64'({bus.m0_rdata, bus.m0_ack, bus.m0_err}),
              64'({e_rdata[0], e_ack[0], e_err[0]}));
        check("m1_resp", 64'({bus.m1_rdata, bus.m1_ack, bus.m1_err}),
              64'({e_rdata[1], e_ack[1], e_err[1]}));
      end
      armed = 1;
      if (rst) begin
        model_reset();
      end else if (responding) begin
        e_ack = '0; e_err = '0; e_busy = 0; responding = 0;
      end else if (busy_cycles > 0) begin
        if (bus.s_ack || busy_cycles == TO) begin
          e_rdata[owner] = bus.s_ack ? bus.s_rdata : '0;
          e_ack[owner]   = 1'b1;
          e_err[owner]   = !bus.s_ack;
          e_rd = 0; e_wr = 0;
          busy_cycles = 0; responding = 1;
        end else begin
          busy_cycles++;
        end
      end else begin
        r0 = bus.m0_rd || bus.m0_wr;
        r1 = bus.m1_rd || bus.m1_wr;
        if (r0 || r1) begin
          owner   = (r0 && r1) ? !lastg : r1;
          lastg   = owner;
          e_addr  = owner ? bus.m1_addr  : bus.m0_addr;
          e_wdata = owner ? bus.m1_wdata : bus.m0_wdata;
          e_bval  = owner ? bus.m1_bval  : bus.m0_bval;
          e_wr    = owner ? bus.m1_wr    : bus.m0_wr;
          e_rd    = (owner ? bus.m1_rd : bus.m0_rd) && !e_wr;
          e_busy  = 1; busy_cycles = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_req(input bit m, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
    if (m) begin
      bus.m1_rd = rd; bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_bval = b;
    end else begin
      bus.m0_rd = rd; bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_bval = b;
    end
  endtask

  task automatic clr_req(input bit m);
    set_req(m, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // From an IDLE cycle with a request visible: runs until an ack appears.
  // ack_at = BUSY cycle in which s_ack is driven (0 = never). Ends in the ack cycle.
  task automatic serve(input int ack_at, input logic [DW-1:0] rdata, output int who,
                       output int nb);
    who = -1;
    nb  = 0;
    tick();
    for (int k = 1; k <= int'(TO) + 2; k++) begin
      if (k == ack_at) begin
        bus.s_ack = 1'b1; bus.s_rdata = rdata;
      end
      tick();
      bus.s_ack = 1'b0;
      if (bus.m0_ack || bus.m1_ack) begin
        who = bus.m1_ack ? 1 : 0;
        nb  = k;
        break;
      end
    end
    check("ack_seen", 64'(who >= 0), 64'(1));
  endtask

  initial begin
    int who, nb;
    clr_req(0); clr_req(1);
    bus.s_ack = 1'b0; bus.s_rdata = '0;
    rst = 1'b1;
    repeat (2) tick();
    check("reset_state",
          64'({bus.busy, bus.s_rd, bus.s_wr, bus.s_addr, bus.m0_ack, bus.m1_ack, bus.m0_err,
               bus.m1_err, bus.m0_rdata}), 64'(0));
    rst = 1'b0;

    // Tie right after reset, then strict alternation; ack in first BUSY cycle.
    set_req(0, 1, 0, 16'h0100, '0, 4'hF);
    set_req(1, 1, 0, 16'h0200, '0, 4'hF);
    serve(1, 32'h1111_0000, who, nb);
    check("tie1_grant", 64'(who), 64'(0));
    check("throughput_busy_cycles", 64'(nb), 64'(1));
    tick(); clr_req(0);
    serve(1, 32'h2222_0000, who, nb);
    check("tie1_second", 64'(who), 64'(1));
    check("m1_rdata_lit", 64'(bus.m1_rdata), 64'h2222_0000);
    tick(); clr_req(1);
    set_req(0, 1, 0, 16'h0104, '0, 4'hF);
    set_req(1, 1, 0, 16'h0204, '0, 4'hF);
    serve(1, 32'h3333_0000, who, nb);
    check("tie2_grant", 64'(who), 64'(0));
    tick(); clr_req(0);
    serve(1, 32'h4444_0000, who, nb);
    check("tie2_second", 64'(who), 64'(1));
    tick(); clr_req(1);

    // m0 read, s_ack in the second BUSY cycle.
    set_req(0, 1, 0, 16'h0010, '0, 4'hF);
    serve(2, 32'hDEAD_BEEF, who, nb);
    check("rd_ack_cycle", 64'(nb), 64'(2));
    check("rd_resp", 64'({bus.m0_rdata, bus.m0_ack, bus.m0_err, bus.m1_ack}),
          64'({32'hDEAD_BEEF, 3'b100}));
    tick(); clr_req(0);
    check("rd_ack_pulse", 64'({bus.m0_ack, bus.m0_rdata}), 64'({1'b0, 32'hDEAD_BEEF}));

    // m1 write with rd also high: write wins, fields frozen through BUSY.
    set_req(1, 1, 1, 16'h0020, 32'h1234_5678, 4'b0011);
    tick();
    check("wr_fields", 64'({bus.s_addr, bus.s_wdata, bus.s_bval, bus.s_rd, bus.s_wr}),
          64'({16'h0020, 32'h1234_5678, 4'b0011, 2'b01}));
    set_req(1, 1, 1, 16'hFFFF, 32'h0, 4'hF);
    tick();
    check("wr_hold", 64'({bus.s_addr, bus.s_wdata, bus.s_bval, bus.s_rd, bus.s_wr}),
          64'({16'h0020, 32'h1234_5678, 4'b0011, 2'b01}));
    bus.s_ack = 1'b1; bus.s_rdata = 32'h0BAD_F00D;
    tick();
    bus.s_ack = 1'b0;
    check("wr_resp", 64'({bus.m1_ack, bus.m1_err, bus.s_wr, bus.m0_ack}), 64'(4'b1000));
    tick(); clr_req(1);

    // Timeout with no s_ack, then s_ack on the very last BUSY cycle.
    set_req(0, 1, 0, 16'h0030, '0, 4'hF);
    serve(0, '0, who, nb);
    check("to_cycles", 64'(nb), 64'(TO));
    check("to_resp", 64'({bus.m0_rdata, bus.m0_ack, bus.m0_err, bus.s_rd, bus.m1_ack}),
          64'({32'h0, 4'b1100}));
    tick(); clr_req(0);
    set_req(0, 1, 0, 16'h0034, '0, 4'hF);
    serve(int'(TO), 32'hA5A5_0008, who, nb);
    check("late_ack_resp", 64'({bus.m0_rdata, bus.m0_ack, bus.m0_err}),
          64'({32'hA5A5_0008, 2'b10}));
    tick(); clr_req(0);

    // Stray s_ack while idle.
    bus.s_ack = 1'b1; bus.s_rdata = 32'h0000_0077;
    tick(); tick();
    bus.s_ack = 1'b0;
    check("stray_ack", 64'({bus.busy, bus.m0_ack, bus.m1_ack, bus.s_rd, bus.s_wr, bus.m0_rdata}),
          64'({5'b0, 32'hA5A5_0008}));

    // Reset in the middle of BUSY, then a tie must go to m0 again.
    set_req(0, 1, 0, 16'h0040, '0, 4'hF);
    tick(); tick();
    check("pre_abort_busy", 64'({bus.busy, bus.s_rd}), 64'(2'b11));
    rst = 1'b1; clr_req(0);
    tick();
    check("abort", 64'({bus.busy, bus.s_rd, bus.m0_ack, bus.m1_ack}), 64'(0));
    rst = 1'b0;
    set_req(0, 1, 0, 16'h0044, '0, 4'hF);
    set_req(1, 1, 0, 16'h0048, '0, 4'hF);
    serve(1, 32'h5555_0000, who, nb);
    check("post_reset_tie", 64'(who), 64'(0));
    tick(); clr_req(0);
    serve(1, 32'h6666_0000, who, nb);
    check("post_reset_second", 64'(who), 64'(1));
    tick(); clr_req(1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
